// File: rtl/handshake_sender_pkg.sv
// Shared types and link-word helpers for the four-phase frame sender.
// Imported by the top; the optional ack timeout is gated by SENDER_TIMEOUT_EN.
package handshake_sender_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ_HI,
        S_REQ_LO,
        S_DONE
    } state_e;

    localparam int          IDX_W    = 9;
    localparam logic [5:0]  HDR_WORD = 6'b010000;

    // Odd parity over all six bits: the receiver discards any word whose XOR is 0.
    function automatic logic [5:0] link_word(input logic flag, input logic [3:0] nib);
        return {~(flag ^ (^nib)), flag, nib};
    endfunction

    function automatic int chunk_count(input int n);
        return (n + 3) / 4;
    endfunction

endpackage

// File: rtl/handshake_sender_if.sv
// Link-side bundle between the sender board and the four-phase receiver.
interface handshake_sender_if;

    logic       wire_req;
    logic [5:0] wire_data_deliver;
    logic       wire_ack;

    modport master (
        output wire_req,
        output wire_data_deliver,
        input  wire_ack
    );

    modport slave (
        input  wire_req,
        input  wire_data_deliver,
        output wire_ack
    );

endinterface

// File: rtl/handshake_sender_ack_sync_2ff.sv
// Two-flop synchroniser bringing the receiver's ack into the sender clock domain.
module ack_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/handshake_sender.sv
// Serialises an N-bit frame into header + ceil(N/4) parity-protected nibble words over req/ack.
// Define SENDER_TIMEOUT_EN to abort and restart a frame when ack does not rise within TIMEOUT cycles.
module handshake_sender
    import handshake_sender_pkg::*;
#(
    parameter int N = 1500
`ifdef SENDER_TIMEOUT_EN
    , parameter int TIMEOUT = 4096
`endif
) (
    input  logic                clk_sender,
    input  logic                rst_sender,
    input  logic [N-1:0]        data_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    handshake_sender_if.master  link
);

    localparam int               C        = chunk_count(N);
    localparam int               FW       = 4 * C;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C - 1);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [5:0]       word_q, word_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hdr_sent_q, hdr_sent_d;
    logic [IDX_W-1:0] nxt_idx;
    logic [3:0]       nib_sel;
    logic             ack_s;

    ack_sync_2ff u_ack_sync (
        .clk (clk_sender),
        .rst (rst_sender),
        .d   (link.wire_ack),
        .q   (ack_s)
    );

`ifdef SENDER_TIMEOUT_EN
    localparam int             TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             restart_q, restart_d;
    logic             err_q, err_d;
`endif

    // Header occupies its own slot, so the first data word is chunk 0, not idx+1.
    always_comb begin
        nxt_idx = hdr_sent_q ? (idx_q + 1'b1) : '0;
        nib_sel = frame_q[{nxt_idx, 2'b00} +: 4];
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        frame_d    = frame_q;
        idx_d      = idx_q;
        hdr_sent_d = hdr_sent_q;
`ifdef SENDER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        restart_d  = restart_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d    = FW'(data_in);
                    busy_d     = 1'b1;
                    word_d     = HDR_WORD;
                    idx_d      = '0;
                    hdr_sent_d = 1'b0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                req_d   = 1'b1;
                state_d = S_REQ_HI;
`ifdef SENDER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = S_REQ_LO;
                end
`ifdef SENDER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    restart_d = 1'b1;
                    state_d   = S_REQ_LO;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_REQ_LO: begin
                // Word may only move once the receiver has released ack.
                if (!ack_s) begin
`ifdef SENDER_TIMEOUT_EN
                    if (restart_q) begin
                        word_d     = HDR_WORD;
                        idx_d      = '0;
                        hdr_sent_d = 1'b0;
                        restart_d  = 1'b0;
                        state_d    = S_SETUP;
                    end else
`endif
                    if (hdr_sent_q && (idx_q == LAST_IDX)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        word_d     = link_word(1'b0, nib_sel);
                        idx_d      = nxt_idx;
                        hdr_sent_d = 1'b1;
                        state_d    = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sender or posedge rst_sender) begin
        if (rst_sender) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            word_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frame_q    <= '0;
            idx_q      <= '0;
            hdr_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            word_q     <= word_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            hdr_sent_q <= hdr_sent_d;
        end
    end

`ifdef SENDER_TIMEOUT_EN
    always_ff @(posedge clk_sender or posedge rst_sender) begin
        if (rst_sender) begin
            tmo_cnt_q <= '0;
            restart_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            restart_q <= restart_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign link.wire_req          = req_q;
    assign link.wire_data_deliver = word_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule
